// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin sharing of one SPI transmitter among NUM_REQ
// requesters. Each grant loads the winner's CKP/CPH, raises Transaccion, follows
// the transfer via CS, then holds the grant through an inter-transaction gap.
// Optional feature: define SPI_TXN_SCHED_COUNT_EN to add TX_COUNT[7:0], a
// saturating count of successful transactions.
module spi_txn_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 4,
  parameter int START_TO   = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] REQ_CKP,
  input  logic [NUM_REQ-1:0] REQ_CPH,
  output logic [NUM_REQ-1:0] GNT,
  output logic               DONE,
  output logic               ERR,
  output logic               BUSY,
  output logic               Transaccion,
  output logic               CKP,
  output logic               CPH,
  input  logic               CS
`ifdef SPI_TXN_SCHED_COUNT_EN
  ,
  output logic [7:0]         TX_COUNT
`endif
);

  localparam int CMAX = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(NUM_REQ);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t TO_LAST  = cnt_t'(START_TO - 1);
  localparam cnt_t GAP_LAST = cnt_t'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_START, S_ACTIVE, S_GAP} state_t;

  state_t             state, state_n;
  cnt_t               cnt, cnt_n;
  logic [PW-1:0]      ptr, ptr_n;
  logic [PW-1:0]      win;
  logic               any_req;
  logic [NUM_REQ-1:0] gnt_n;
  logic               done_n, err_n, txn_n, ckp_n, cph_n;

  assign BUSY = (state != S_IDLE);

  // Round-robin pick: scan from ptr upward with wrap, first asserted REQ wins.
  always_comb begin
    int j;
    j       = 0;
    any_req = 1'b0;
    win     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_req && REQ[j]) begin
        any_req = 1'b1;
        win     = PW'(j);
      end
    end
  end

  // Next state and next registered outputs; a single counter serves both
  // the start timeout and the gap, since they never overlap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gnt_n   = GNT;
    done_n  = 1'b0;
    err_n   = 1'b0;
    txn_n   = Transaccion;
    ckp_n   = CKP;
    cph_n   = CPH;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_n    = S_CONFIG;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          ckp_n      = REQ_CKP[win];
          cph_n      = REQ_CPH[win];
          ptr_n      = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          cnt_n      = '0;
        end
      end
      // Mode is already on CKP/CPH here; Transaccion follows one cycle later.
      S_CONFIG: begin
        state_n = S_START;
        txn_n   = 1'b1;
        cnt_n   = '0;
      end
      S_START: begin
        if (!CS) begin
          state_n = S_ACTIVE;
        end else if (cnt == TO_LAST) begin
          state_n = S_GAP;
          err_n   = 1'b1;
          txn_n   = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (CS) begin
          state_n = S_GAP;
          done_n  = 1'b1;
          txn_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; async reset aborts any transaction at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      GNT         <= '0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      Transaccion <= 1'b0;
      CKP         <= 1'b0;
      CPH         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      GNT         <= gnt_n;
      DONE        <= done_n;
      ERR         <= err_n;
      Transaccion <= txn_n;
      CKP         <= ckp_n;
      CPH         <= cph_n;
    end
  end

`ifdef SPI_TXN_SCHED_COUNT_EN
  // Successful-transaction counter, updated in step with DONE, sticks at 255.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                         TX_COUNT <= 8'd0;
    else if (done_n && TX_COUNT != 8'hFF) TX_COUNT <= TX_COUNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a scoreboard of expected grants.
// Define SPI_TXN_SCHED_COUNT_EN to also exercise TX_COUNT.
module tb_spi_txn_scheduler;
  localparam int GAP = 4;
  localparam int STO = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [2:0] REQ = '0, REQ_CKP = '0, REQ_CPH = '0;
  logic       CS = 1'b1;
  logic [2:0] GNT;
  logic       DONE, ERR, BUSY, Transaccion, CKP, CPH;
`ifdef SPI_TXN_SCHED_COUNT_EN
  logic [7:0] TX_COUNT;
`endif

  spi_txn_scheduler #(.NUM_REQ(3), .GAP_CYCLES(GAP), .START_TO(STO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_CKP(REQ_CKP), .REQ_CPH(REQ_CPH),
    .GNT(GNT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .Transaccion(Transaccion),
    .CKP(CKP), .CPH(CPH), .CS(CS)
`ifdef SPI_TXN_SCHED_COUNT_EN
    , .TX_COUNT(TX_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc_cnt = 0;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  typedef struct packed {logic [2:0] gnt; logic ckp; logic cph;} exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int t_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_gnt(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      waited++;
      if (GNT != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Serves one granted transaction: to=1 leaves CS high to force a timeout.
  task automatic serve(input bit to, input logic [2:0] drop, input bit b2b, input int exp_wait);
    exp_t e;
    bit   ok;
    int   waited;
    wait_gnt(ok, waited);
    if (!ok) return;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (exp_wait > 0) chk("gnt_latency", waited, exp_wait);
    chk("gnt", GNT, e.gnt);
    chk("ckp", CKP, e.ckp);
    chk("cph", CPH, e.cph);
    chk("cfg_txn_low", Transaccion, 0);
    @(negedge CLK);
    chk("txn_rise", Transaccion, 1);
    if (b2b) chk("b2b_spacing", cyc_cnt - t_done, GAP + 2);
    if (!to) begin
      cyc(2);
      CS = 1'b0;
      cyc(20);
      chk("txn_active", Transaccion, 1);
      CS = 1'b1;
      @(negedge CLK);
      chk("done", DONE, 1);
      chk("no_err", ERR, 0);
    end else begin
      cyc(STO - 1);
      chk("err_early", ERR, 0);
      chk("to_txn_high", Transaccion, 1);
      @(negedge CLK);
      chk("err", ERR, 1);
      chk("no_done", DONE, 0);
    end
    t_done = cyc_cnt;
    chk("txn_fall", Transaccion, 0);
    REQ = REQ & ~drop;
    @(negedge CLK);
    chk("pulse_once", {DONE, ERR}, 0);
    cyc(2);
    chk("gnt_hold", GNT, e.gnt);
    @(negedge CLK);
    chk("gnt_clr", GNT, 0);
  endtask

  initial begin
    bit ok;
    int waited;
    // Reset state
    cyc(2);
    chk("rst_gnt", GNT, 0);
    chk("rst_flags", {DONE, ERR, BUSY, Transaccion}, 0);
    chk("rst_mode", {CKP, CPH}, 0);
`ifdef SPI_TXN_SCHED_COUNT_EN
    chk("rst_cnt", TX_COUNT, 0);
`endif
    RESET = 1'b1;
    cyc(2);
    chk("idle_busy", BUSY, 0);

    // Single request, CKP=1 CPH=0
    REQ_CKP = 3'b001; REQ_CPH = 3'b000; REQ = 3'b001;
    sb.push_back('{3'b001, 1'b1, 1'b0});
    serve(1'b0, 3'b001, 1'b0, 1);
    chk("single_idle", BUSY, 0);

    // Contention from reset: rotating 0,1,2,0
    RESET = 1'b0;
    REQ = 3'b111; REQ_CKP = 3'b101; REQ_CPH = 3'b110;
    cyc(1);
    RESET = 1'b1;
    sb.push_back('{3'b001, 1'b1, 1'b0});
    sb.push_back('{3'b010, 1'b0, 1'b1});
    sb.push_back('{3'b100, 1'b1, 1'b1});
    sb.push_back('{3'b001, 1'b1, 1'b0});
    serve(1'b0, 3'b000, 1'b0, 1);
    serve(1'b0, 3'b000, 1'b1, 1);
    serve(1'b0, 3'b000, 1'b1, 1);
    serve(1'b0, 3'b111, 1'b1, 1);

    // Timeout on requester 1 (pointer now 1)
    REQ = 3'b010;
    sb.push_back('{3'b010, 1'b0, 1'b1});
    serve(1'b1, 3'b010, 1'b0, 1);

    // Withdrawal: REQ[2] pulse while serving 0, REQ[0] drop in ACTIVE
    REQ = 3'b001;
    wait_gnt(ok, waited);
    chk("wd_gnt", GNT, 3'b001);
    @(negedge CLK);
    CS = 1'b0; REQ = 3'b101;
    @(negedge CLK);
    REQ = 3'b000;
    cyc(3);
    CS = 1'b1;
    @(negedge CLK);
    chk("wd_done", DONE, 1);
    chk("wd_gnt_held", GNT, 3'b001);
    cyc(GAP + 10);
    chk("wd_no_regrant", {BUSY, GNT}, 0);

    // Reset mid-ACTIVE, pointer returns to 0
    REQ = 3'b001;
    wait_gnt(ok, waited);
    @(negedge CLK);
    CS = 1'b0;
    cyc(2);
    chk("pre_rst_txn", {Transaccion, CKP, GNT}, 5'b11001);
    #2 RESET = 1'b0;
    #1;
    chk("arst_txn", Transaccion, 0);
    chk("arst_gnt", GNT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_mode", {CKP, CPH}, 0);
    CS = 1'b1; REQ = 3'b000;
    @(negedge CLK);
    chk("arst_no_flags", {DONE, ERR}, 0);
    RESET = 1'b1;
    REQ = 3'b011;
    sb.push_back('{3'b001, 1'b1, 1'b0});
    serve(1'b0, 3'b011, 1'b0, 1);

`ifdef SPI_TXN_SCHED_COUNT_EN
    RESET = 1'b0;
    cyc(1);
    chk("cnt_rst", TX_COUNT, 0);
    RESET = 1'b1;
    REQ = 3'b001;
    for (int k = 0; k < 260; k++) begin
      sb.push_back('{3'b001, 1'b1, 1'b0});
      serve(1'b0, 3'b000, (k != 0), -1);
      if (k == 9) chk("cnt_10", TX_COUNT, 10);
    end
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{3'b001, 1'b1, 1'b0});
      serve(1'b1, (k == 2) ? 3'b001 : 3'b000, 1'b1, -1);
    end
    chk("cnt_sat", TX_COUNT, 255);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
